// File: rtl/alu_seq_mdu.sv
// Sequential ALU with iterative RV32M-style multiply/divide behind valid/ready handshakes.
// Optional define MDU_FAST_ZERO_EN: zero-operand multiplies and zero-divisor divides finish in one cycle.
module alu_seq_mdu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [4:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);
   // state  | meaning
   // S_IDLE | waiting for an operation, in_ready high
   // S_CALC | one multiply/divide bit per cycle, cnt counts down to 0
   // S_DONE | result presented, waiting for out_ready
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t state, state_nx;

   logic [2:0]         m_op;
   logic [WIDTH-1:0]   ma, mb, p_hi, p_lo, a_q;
   logic               neg_q, neg_r, b_zero;
   logic [SHAMT_W-1:0] cnt;

   logic               accept, a_sgn, b_sgn, fast_m, one_cycle;
   logic [WIDTH-1:0]   abs_a, abs_b, alu_res, imm_res, fast_res;
   logic [SHAMT_W-1:0] shamt;

   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   hi_nx, lo_nx, quo, rem, div_res, mul_res, m_res;
   logic [2*WIDTH-1:0] prod, prod_s;

   assign accept = in_valid && (state == S_IDLE);
   assign shamt  = src_b[SHAMT_W-1:0];

   // MULH, MULHSU, DIV and REM treat src_a as signed; MULH, DIV, REM also src_b.
   assign a_sgn = op[4] && src_a[WIDTH-1] &&
                  (op[2:0] == 3'b001 || op[2:0] == 3'b010 ||
                   op[2:0] == 3'b100 || op[2:0] == 3'b110);
   assign b_sgn = op[4] && src_b[WIDTH-1] &&
                  (op[2:0] == 3'b001 || op[2:0] == 3'b100 || op[2:0] == 3'b110);
   assign abs_a = a_sgn ? -src_a : src_a;
   assign abs_b = b_sgn ? -src_b : src_b;

   always_comb begin
      alu_res = '0;
      case (op[3:0])
         4'b0000: alu_res = src_a & src_b;
         4'b0001: alu_res = src_a | src_b;
         4'b0010: alu_res = src_a + src_b;
         4'b0011: alu_res = $signed(src_a) >>> shamt;
         4'b0110: alu_res = src_a - src_b;
         4'b0111: alu_res = WIDTH'($signed(src_a) < $signed(src_b));
         4'b1000: alu_res = src_a << shamt;
         4'b1001: alu_res = src_a >> shamt;
         4'b1010: alu_res = src_a ^ src_b;
         4'b1011: alu_res = WIDTH'($signed(src_a) >= $signed(src_b));
         4'b1100: alu_res = ~(src_a | src_b);
         4'b1101: alu_res = WIDTH'(src_a >= src_b);
         4'b1110: alu_res = src_a - src_b;
         4'b1111: alu_res = WIDTH'(src_a < src_b);
         default: alu_res = '0;
      endcase
   end

`ifdef MDU_FAST_ZERO_EN
   assign fast_m = op[4] && !op[3] &&
                   (op[2] ? (src_b == '0) : (src_a == '0 || src_b == '0));
`else
   assign fast_m = 1'b0;
`endif

   assign fast_res  = op[2] ? (op[1] ? src_a : '1) : '0;
   assign one_cycle = !op[4] || op[3] || fast_m;
   assign imm_res   = !op[4] ? alu_res : (op[3] ? '0 : fast_res);

   // Multiply: {p_hi,p_lo} shifts right, adding ma when the multiplier bit is set.
   // Divide: p_hi holds the partial remainder, p_lo shifts dividend out and quotient in.
   assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, ma} : '0);
   assign div_sh   = {p_hi, p_lo[WIDTH-1]};
   assign div_ge   = div_sh >= {1'b0, mb};
   assign div_diff = div_sh - {1'b0, mb};

   always_comb begin
      if (m_op[2]) begin
         hi_nx = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
         lo_nx = {p_lo[WIDTH-2:0], div_ge};
      end else begin
         hi_nx = mul_sum[WIDTH:1];
         lo_nx = {mul_sum[0], p_lo[WIDTH-1:1]};
      end
   end

   assign prod    = {hi_nx, lo_nx};
   assign prod_s  = neg_q ? -prod : prod;
   assign mul_res = (m_op[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
   assign quo     = neg_q ? -lo_nx : lo_nx;
   assign rem     = neg_r ? -hi_nx : hi_nx;
   assign div_res = b_zero ? (m_op[1] ? a_q : '1) : (m_op[1] ? rem : quo);
   assign m_res   = m_op[2] ? div_res : mul_res;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (accept) state_nx = one_cycle ? S_DONE : S_CALC;
         end
         S_CALC: if (cnt == '0) state_nx = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         zero   <= 1'b1;
         cnt    <= '0;
         m_op   <= '0;
         ma     <= '0;
         mb     <= '0;
         p_hi   <= '0;
         p_lo   <= '0;
         a_q    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               m_op   <= op[2:0];
               ma     <= abs_a;
               mb     <= abs_b;
               p_hi   <= '0;
               p_lo   <= op[2] ? abs_a : abs_b;
               a_q    <= src_a;
               neg_q  <= a_sgn ^ b_sgn;
               neg_r  <= a_sgn;
               b_zero <= (src_b == '0);
               cnt    <= SHAMT_W'(WIDTH - 1);
               if (one_cycle) begin
                  result <= imm_res;
                  zero   <= (imm_res == '0);
               end
            end
            S_CALC: begin
               p_hi <= hi_nx;
               p_lo <= lo_nx;
               if (cnt == '0) begin
                  result <= m_res;
                  zero   <= (m_res == '0);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq_mdu.sv
// Directed bench for alu_seq_mdu: literal expectations per vector plus a
// behavioural model checked by a compare process while out_valid is high.
module tb_alu_seq_mdu;
   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, zero, busy;
   logic [31:0] src_a, src_b, result;
   logic [4:0]  op;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_q[$];

   localparam logic [4:0] AND_ = 5'b00000, OR_ = 5'b00001, ADD = 5'b00010, SRA = 5'b00011,
      SUB = 5'b00110, SLT = 5'b00111, SLL = 5'b01000, SRL = 5'b01001, XOR_ = 5'b01010,
      BGE = 5'b01011, NOR_ = 5'b01100, GEU = 5'b01101, BEQ = 5'b01110, SLTU = 5'b01111,
      MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011,
      DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

   alu_seq_mdu #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .src_a(src_a), .src_b(src_b), .op(op), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      p  = 0;
      case (o)
         AND_: return a & b;
         OR_:  return a | b;
         ADD:  return a + b;
         SRA:  return 32'($signed(a) >>> b[4:0]);
         SUB:  return a - b;
         SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         SLL:  return a << b[4:0];
         SRL:  return a >> b[4:0];
         XOR_: return a ^ b;
         BGE:  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         NOR_: return ~(a | b);
         GEU:  return (a >= b) ? 32'd1 : 32'd0;
         BEQ:  return a - b;
         SLTU: return (a < b) ? 32'd1 : 32'd0;
         MUL:    begin p = ua * ub; return p[31:0];  end
         MULH:   begin p = sa * sb; return p[63:32]; end
         MULHSU: begin p = sa * ub; return p[63:32]; end
         MULHU:  begin p = ua * ub; return p[63:32]; end
         DIV:  begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         DIVU: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
         REM:  begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         REMU: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
         default: return 32'd0;
      endcase
   endfunction

   function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      if (!o[4] || o[3]) return 1;
`ifdef MDU_FAST_ZERO_EN
      if (o[2] && b == 0) return 1;
      if (!o[2] && (a == 0 || b == 0)) return 1;
`endif
      return 33;
   endfunction

   // Compare process: every cycle a result is presented it must match the model.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            chk("model_result", result, exp_q[0]);
            chk("model_zero", {31'd0, zero}, {31'd0, exp_q[0] == 32'd0});
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic run_vec(input string name, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input int hold);
      int lat;
      bit got;
      @(negedge clk);
      chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      exp_q.push_back(model(o, a, b));
      in_valid = 1'b0; op = 5'($urandom); src_a = $urandom; src_b = $urandom;
      lat = 0; got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid) got = 1;
      end
      if (!got) begin
         chk({name, "_timeout"}, 32'd0, 32'd1);
         exp_q.delete();
         return;
      end
      chk({name, "_latency"}, lat, exp_lat(o, a, b));
      chk({name, "_result"}, result, e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, "_hold_valid_ready"}, {30'd0, out_valid, in_ready}, 32'd2);
         chk({name, "_hold_result"}, result, e);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      chk({name, "_release"}, {29'd0, out_valid, busy, in_ready}, 32'd1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; src_a = '0; src_b = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_flags", {28'd0, out_valid, busy, in_ready, zero}, 32'h3);
      chk("reset_result", result, 32'd0);

      run_vec("add_ovf",  ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
      run_vec("sub_zero", SUB,  32'd5, 32'd5, 32'd0, 0);
      run_vec("sra",      SRA,  32'h8000_0000, 32'h21, 32'hC000_0000, 0);
      run_vec("slt",      SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 0);
      run_vec("sltu",     SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
      run_vec("bge",      BGE,  32'hFFFF_FFFF, 32'd1, 32'd0, 0);
      run_vec("and",      AND_, 32'hF0F0, 32'hFF00, 32'hF000, 0);
      run_vec("or",       OR_,  32'hF0F0, 32'h0F0F, 32'hFFFF, 0);
      run_vec("xor",      XOR_, 32'hFF, 32'h0F, 32'hF0, 0);
      run_vec("nor",      NOR_, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
      run_vec("sll",      SLL,  32'd1, 32'h25, 32'h20, 0);
      run_vec("srl",      SRL,  32'h8000_0000, 32'd4, 32'h0800_0000, 0);
      run_vec("geu",      GEU,  32'd1, 32'hFFFF_FFFF, 32'd0, 0);
      run_vec("beq",      BEQ,  32'd9, 32'd4, 32'd5, 0);
      run_vec("mul",      MUL,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0);
      run_vec("mulh",     MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
      run_vec("mulhu",    MULHU, 32'hFFFF_FFFF, 32'd2, 32'h1, 0);
      run_vec("mulhsu_n", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
      run_vec("mulhsu_p", MULHSU, 32'd2, 32'hFFFF_FFFF, 32'h1, 0);
      run_vec("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
      run_vec("mul_zero", MUL,  32'd0, 32'h12345, 32'd0, 0);
      run_vec("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_vec("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
      run_vec("divu_0",   DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);
      run_vec("remu_0",   REMU, 32'd7, 32'd0, 32'd7, 0);
      run_vec("div_0",    DIV,  32'd7, 32'd0, 32'hFFFF_FFFF, 0);
      run_vec("rem_0",    REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
      run_vec("div_neg",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
      run_vec("rem_neg",  REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
      run_vec("divu",     DIVU, 32'd100, 32'd7, 32'd14, 5);
      run_vec("remu",     REMU, 32'd100, 32'd7, 32'd2, 0);
      run_vec("m_other",  5'b11000, 32'd3, 32'd4, 32'd0, 0);
      run_vec("divu9_0",  DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);

      // Reset in the middle of a divide; an ADD offered during reset is dropped.
      @(negedge clk);
      in_valid = 1'b1; op = DIV; src_a = 32'd1000; src_b = 32'd3;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1; in_valid = 1'b1; op = ADD; src_a = 32'd1; src_b = 32'd1;
      @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("midcalc_reset_flags", {28'd0, out_valid, busy, in_ready, zero}, 32'h3);
      chk("midcalc_reset_result", result, 32'd0);
      @(negedge clk);
      chk("reset_in_valid_dropped", {31'd0, busy}, 32'd0);
      exp_q.delete();
      run_vec("add_after_reset", ADD, 32'd2, 32'd3, 32'd5, 0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
